// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Bit-serial ALU sequencer. An accepted start captures two WIDTH-bit operands,
// the 4-bit ALU control word {A_invert, B_invert, operation[1:0]} and a 3-bit
// compare select. The operands are then walked LSB first, one bit per clock,
// through a single 1-bit ALU slice (AND / OR / ADD / LESS) whose carry is held
// in a register between cycles. The results match a WIDTH-slice ripple ALU.
//
// Ports
//   clk          in   1      clock, all state changes on the rising edge
//   rst          in   1      synchronous reset, active-high
//   start        in   1      request, sampled only while idle
//   src1         in   WIDTH  operand A, captured on an accepted start
//   src2         in   WIDTH  operand B, captured on an accepted start
//   ALU_control  in   4      {A_invert, B_invert, operation[1:0]}
//   comp         in   3      compare select (used when operation == 3)
//   busy         out  1      high while running or presenting the result
//   done         out  1      one-cycle pulse, outputs valid
//   result       out  WIDTH  result, held until the next accepted start
//   zero         out  1      result == 0
//   cout         out  1      carry out of the MSB (operation == 2 only)
//   overflow     out  1      signed overflow (operation == 2 only)
// ---------------------------------------------------------------------------
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    input  logic [2:0]       comp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Registered state and outputs
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] src2_q, src2_d;
    logic             ainv_q, ainv_d;
    logic             binv_q, binv_d;
    logic [1:0]       op_q, op_d;
    logic [2:0]       comp_q, comp_d;
    logic             carry_q, carry_d;
    logic             eq_acc_q, eq_acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;

    // Slice signals for the bit currently addressed by cnt_q
    logic             bit_a_s;
    logic             bit_b_s;
    logic             sum_s;
    logic             carry_nxt_s;
    logic             slice_r_s;
    logic             eq_nxt_s;
    logic             ovf_s;
    logic             less_s;
    logic             cmp_s;
    logic [WIDTH-1:0] res_bits_s;
    logic [WIDTH-1:0] final_res_s;

    // One-bit ALU slice, compare decode and the assembled final result
    always_comb begin
        bit_a_s     = src1_q[cnt_q] ^ ainv_q;
        bit_b_s     = src2_q[cnt_q] ^ binv_q;
        sum_s       = bit_a_s ^ bit_b_s ^ carry_q;
        carry_nxt_s = (bit_a_s & bit_b_s) | ((bit_a_s | bit_b_s) & carry_q);
        // Equality looks at the raw operands, independent of the invert bits
        eq_nxt_s    = eq_acc_q & ~(src1_q[cnt_q] ^ src2_q[cnt_q]);
        // Only meaningful at the MSB: sign-change overflow and overflow-corrected less
        ovf_s       = ~(bit_a_s ^ bit_b_s) & (bit_a_s ^ sum_s);
        less_s      = sum_s ^ ovf_s;

        case (op_q)
            2'd0:    slice_r_s = bit_a_s & bit_b_s;
            2'd1:    slice_r_s = bit_a_s | bit_b_s;
            2'd2:    slice_r_s = sum_s;
            default: slice_r_s = sum_s;
        endcase

        case (comp_q)
            3'd0:    cmp_s = less_s;
            3'd1:    cmp_s = ~less_s & ~eq_nxt_s;
            3'd2:    cmp_s = less_s | eq_nxt_s;
            3'd3:    cmp_s = ~less_s;
            3'd4:    cmp_s = eq_nxt_s;
            3'd5:    cmp_s = ~eq_nxt_s;
            default: cmp_s = 1'b0;
        endcase

        res_bits_s        = result_q;
        res_bits_s[cnt_q] = slice_r_s;

        if (op_q == 2'd3) begin
            final_res_s = {{(WIDTH-1){1'b0}}, cmp_s};
        end else begin
            final_res_s = res_bits_s;
        end
    end

    // Next-state logic for the sequencer and all registered outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        ainv_d     = ainv_q;
        binv_d     = binv_q;
        op_d       = op_q;
        comp_d     = comp_q;
        carry_d    = carry_q;
        eq_acc_d   = eq_acc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        result_d   = result_q;
        zero_d     = zero_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d    = ST_RUN;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    src1_d     = src1;
                    src2_d     = src2;
                    op_d       = ALU_control[1:0];
                    comp_d     = comp;
                    eq_acc_d   = 1'b1;
                    zero_d     = 1'b0;
                    cout_d     = 1'b0;
                    overflow_d = 1'b0;
                    // Compare always subtracts, whatever invert bits came with it
                    if (ALU_control[1:0] == 2'd3) begin
                        ainv_d  = 1'b0;
                        binv_d  = 1'b1;
                        carry_d = 1'b1;
                    end else begin
                        ainv_d  = ALU_control[3];
                        binv_d  = ALU_control[2];
                        carry_d = ALU_control[2];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                carry_d  = carry_nxt_s;
                eq_acc_d = eq_nxt_s;
                if (op_q != 2'd3) begin
                    result_d = res_bits_s;
                end else begin
                    result_d = result_q;
                end
                if (cnt_q == LAST_BIT) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = final_res_s;
                    zero_d   = (final_res_s == {WIDTH{1'b0}});
                    if (op_q == 2'd2) begin
                        cout_d     = carry_nxt_s;
                        overflow_d = ovf_s;
                    end else begin
                        cout_d     = 1'b0;
                        overflow_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; an in-flight operation is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            ainv_q     <= 1'b0;
            binv_q     <= 1'b0;
            op_q       <= 2'd0;
            comp_q     <= 3'd0;
            carry_q    <= 1'b0;
            eq_acc_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            ainv_q     <= ainv_d;
            binv_q     <= binv_d;
            op_q       <= op_d;
            comp_q     <= comp_d;
            carry_q    <= carry_d;
            eq_acc_q   <= eq_acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule
